// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//
// Time-multiplexed scanner for a DIGITS-wide common-anode seven-segment
// display. A double-buffered hex value (shadow -> disp) is presented one
// digit at a time to a downstream registered hex-to-segment decoder. Each
// digit slot lasts PRESCALE cycles. The first BLANK_CYCLES cycles of every
// slot keep all anodes off, which hides the decoder's one-cycle latency and
// prevents ghosting.
//
// Parameters:
//   DIGITS        number of display digits (>= 2)
//   PRESCALE      clock cycles per digit slot (> BLANK_CYCLES)
//   BLANK_CYCLES  cycles at the start of each slot with all anodes off (>= 1)
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST    in   synchronous active-high reset
//   VALUE  in   4*DIGITS value, digit i = VALUE[4i+3:4i], digit 0 rightmost
//   LOAD   in   one-cycle strobe capturing VALUE into the shadow register
//   D      out  4-bit nibble for the current digit (to decoder D input)
//   AN     out  active-low anode enables (1 = off)
//   FRAME  out  one-cycle pulse at the start of each digit-0 slot
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digit i>0 stays dark during SHOW if
//                          nibbles i..DIGITS-1 of disp are all zero.
//
// Slot FSM (decoded from cnt):
//   state | meaning
//   BLANK | cnt < BLANK_CYCLES, all anodes off
//   SHOW  | remainder of the slot, anode of digit idx on

module seg_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   VALUE,
    input  logic                  LOAD,
    output logic [3:0]            D,
    output logic [DIGITS-1:0]     AN,
    output logic                  FRAME
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(DIGITS);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] shadow;
    logic [4*DIGITS-1:0] disp;
    logic                pending;

    logic                slot_end;
    logic                wrap;
    logic                commit;
    logic [CW-1:0]       cnt_next;
    logic [IW-1:0]       idx_next;
    logic [4*DIGITS-1:0] disp_next;
    logic [0:0]          state_next;
    logic [DIGITS-1:0]   lz_hide;
    logic [DIGITS-1:0]   an_next;

    always_comb begin
        slot_end   = (cnt == CNT_LAST);
        wrap       = slot_end && (idx == IDX_LAST);
        commit     = wrap && pending;
        cnt_next   = slot_end ? '0 : cnt + CW'(1);
        idx_next   = idx;
        if (slot_end) begin
            idx_next = wrap ? '0 : idx + IW'(1);
        end
        // Committed data is visible in the same edge that starts digit 0,
        // so a whole frame always shows one consistent value.
        disp_next  = commit ? shadow : disp;
        state_next = (cnt_next < CNT_BLANK) ? ST_BLANK : ST_SHOW;
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the most significant digit down; a digit is hidden while
    // every nibble from it upward is zero. Digit 0 is never hidden.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz_hide    = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (disp_next[4*i +: 4] == 4'h0);
            lz_hide[i] = upper_zero;
        end
    end
`else
    always_comb begin
        lz_hide = '0;
    end
`endif

    always_comb begin
        an_next = '1;
        if (state_next == ST_SHOW) begin
            an_next = ~(DIGITS'(1) << idx_next) | lz_hide;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt     <= '0;
            idx     <= '0;
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
            D       <= 4'h0;
            AN      <= '1;
            FRAME   <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            idx   <= idx_next;
            disp  <= disp_next;
            AN    <= an_next;
            // No pulse for the frame that begins at reset release; the
            // first pulse comes with the first wrap.
            FRAME <= wrap;
            if (slot_end) begin
                D <= disp_next[4*int'(idx_next) +: 4];
            end
            // A LOAD on the wrap edge re-arms pending after the commit.
            if (LOAD) begin
                shadow  <= VALUE;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int DIGITS = 4;
    localparam int PRESCALE = 8;
    localparam int BLANK_CYCLES = 2;

    logic        CLK;
    logic        RST;
    logic [15:0] VALUE;
    logic        LOAD;
    logic [3:0]  D;
    logic [3:0]  AN;
    logic        FRAME;

    int total = 0;
    int bad = 0;

    // Reference model of the display state, written from the behavioural
    // description of the scanner.
    int          m_cnt = 0;
    int          m_idx = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_shadow = '0;
    logic        m_pending = 1'b0;
    logic        m_frame = 1'b0;
    logic [3:0]  d_q[$];

    seg_scan_driver #(
        .DIGITS(DIGITS),
        .PRESCALE(PRESCALE),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .VALUE(VALUE),
        .LOAD(LOAD),
        .D(D),
        .AN(AN),
        .FRAME(FRAME)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cnt=%0d idx=%0d)", tag, obs, exp, m_cnt, m_idx);
        end
    endtask

    function automatic logic [3:0] model_an();
        logic [3:0] a;
        if (m_cnt < BLANK_CYCLES) return 4'hF;
        a = ~(4'b0001 << m_idx);
`ifdef LEADING_ZERO_BLANK_EN
        if (m_idx > 0 && (m_disp >> (4 * m_idx)) == 16'h0) a = 4'hF;
`endif
        return a;
    endfunction

    // One clock cycle: drive inputs, advance the model at the edge, then
    // compare DUT outputs 1 time unit after the edge.
    task automatic cyc(input logic ld, input logic [15:0] val, input logic rst);
        logic slot_end;
        logic wrap;
        logic [3:0] exp_d;
        LOAD = ld;
        VALUE = val;
        RST = rst;
        @(posedge CLK);
        if (rst) begin
            m_cnt = 0;
            m_idx = 0;
            m_disp = '0;
            m_shadow = '0;
            m_pending = 1'b0;
            m_frame = 1'b0;
            d_q.delete();
            d_q.push_back(4'h0);
        end else begin
            slot_end = (m_cnt == PRESCALE - 1);
            wrap = slot_end && (m_idx == DIGITS - 1);
            if (wrap && m_pending) begin
                m_disp = m_shadow;
                m_pending = 1'b0;
            end
            if (ld) begin
                m_shadow = val;
                m_pending = 1'b1;
            end
            m_frame = wrap;
            if (slot_end) begin
                m_cnt = 0;
                m_idx = wrap ? 0 : m_idx + 1;
                d_q.push_back(4'((m_disp >> (4 * m_idx)) & 16'hF));
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        #1;
        LOAD = 1'b0;
        RST = 1'b0;
        check("an", 32'(AN), 32'(model_an()));
        check("frame", 32'(FRAME), 32'(m_frame));
        if (d_q.size() > 0) begin
            exp_d = d_q.pop_front();
            check("d_slot", 32'(D), 32'(exp_d));
        end
    endtask

    task automatic run_to(input int i, input int c);
        for (int k = 0; k < 64 && !(m_idx == i && m_cnt == c); k++) cyc(1'b0, 16'h0, 1'b0);
    endtask

    task automatic check_frame_digits(input string tag, input logic [15:0] v);
        for (int s = 0; s < DIGITS; s++) begin
            run_to(s, 0);
            check(tag, 32'(D), 32'((v >> (4 * s)) & 16'hF));
        end
    endtask

    initial begin
        logic [15:0] prev;
        RST = 1'b1;
        LOAD = 1'b0;
        VALUE = '0;

        // reset and idle rotation
        cyc(1'b0, 16'h0, 1'b1);
        cyc(1'b0, 16'h0, 1'b1);
        check("rst_an", 32'(AN), 32'h0000000F);
        check("rst_d", 32'(D), 32'h0);
        check("rst_frame", 32'(FRAME), 32'h0);
        run_to(0, 1);
        check("blank_c1", 32'(AN), 32'hF);
        run_to(0, 2);
        check("an_d0", 32'(AN), 32'hE);
        run_to(1, 2);
        check("an_d1", 32'(AN), 32'hD);
        run_to(2, 2);
        check("an_d2", 32'(AN), 32'hB);
        run_to(3, 2);
        check("an_d3", 32'(AN), 32'h7);

        // mid-frame load, visible only after the wrap
        run_to(1, 3);
        cyc(1'b1, 16'hA5C3, 1'b0);
        run_to(3, 7);
        check("hold_old", 32'(D), 32'h0);
        cyc(1'b0, 16'h0, 1'b0);
        check("frame_pulse", 32'(FRAME), 32'h1);
        check("commit_d0", 32'(D), 32'h3);
        check_frame_digits("a5c3", 16'hA5C3);

        // last write wins
        run_to(1, 1);
        cyc(1'b1, 16'h1234, 1'b0);
        run_to(2, 4);
        cyc(1'b1, 16'h5678, 1'b0);
        run_to(0, 0);
        check_frame_digits("last_wins", 16'h5678);

        // load on the wrap edge with nothing pending
        run_to(3, 7);
        cyc(1'b1, 16'hBEEF, 1'b0);
        check_frame_digits("wrap_prev", 16'h5678);
        run_to(0, 0);
        check_frame_digits("beef", 16'hBEEF);

        // load on the wrap edge while another value is pending
        run_to(2, 0);
        cyc(1'b1, 16'h1357, 1'b0);
        run_to(3, 7);
        prev = 16'h1357;
        cyc(1'b1, 16'h2468, 1'b0);
        check_frame_digits("wrap_old", prev);
        run_to(0, 0);
        check_frame_digits("wrap_new", 16'h2468);

        // reset mid-slot with a pending load
        run_to(1, 4);
        cyc(1'b1, 16'h9999, 1'b0);
        run_to(2, 5);
        cyc(1'b0, 16'h0, 1'b1);
        check("mid_rst_an", 32'(AN), 32'hF);
        check("mid_rst_d", 32'(D), 32'h0);
        check("mid_rst_frame", 32'(FRAME), 32'h0);
        run_to(0, 2);
        check("resume_an", 32'(AN), 32'hE);
        run_to(0, 0);
        check_frame_digits("cleared", 16'h0000);

`ifdef LEADING_ZERO_BLANK_EN
        run_to(1, 0);
        cyc(1'b1, 16'h0040, 1'b0);
        run_to(0, 2);
        run_to(0, 0);
        run_to(0, 2);
        check("lz_d0_an", 32'(AN), 32'hE);
        check("lz_d0_d", 32'(D), 32'h0);
        run_to(1, 2);
        check("lz_d1_an", 32'(AN), 32'hD);
        check("lz_d1_d", 32'(D), 32'h4);
        run_to(2, 5);
        check("lz_d2_an", 32'(AN), 32'hF);
        run_to(3, 5);
        check("lz_d3_an", 32'(AN), 32'hF);
`endif

        run_to(0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
